// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access sizes, FSM
// state encoding and the lane helpers used for stores and alignment checks.
package mem_stage_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'd0;
    localparam logic [1:0] MEM_SZ_H = 2'd1;
    localparam logic [1:0] MEM_SZ_W = 2'd2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    // Half-words need an even address, words need a 4-byte boundary.
    // The unused size code 3 is treated like a word.
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic mis;
        case (size)
            MEM_SZ_B: mis = 1'b0;
            MEM_SZ_H: mis = addr[0];
            default:  mis = (addr != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] mem_be(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            MEM_SZ_B: be = 4'b0001 << addr;
            MEM_SZ_H: be = 4'b0011 << addr;
            default:  be = 4'hF;
        endcase
        return be;
    endfunction

    // Store data is replicated onto every lane; the byte enables pick the lane.
    function automatic logic [31:0] mem_wdata(input logic [1:0] size, input logic [31:0] din);
        logic [31:0] wd;
        case (size)
            MEM_SZ_B: wd = {4{din[7:0]}};
            MEM_SZ_H: wd = {2{din[15:0]}};
            default:  wd = din;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus between the memory stage and memory.
interface mem_stage_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of the returned word and extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by sign or zero extension.
    always_comb begin
        byte_v = 8'h00;
        half_v = 16'h0000;
        data   = rdata;
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_SZ_B: data = {{24{~uns & byte_v[7]}}, byte_v};
            MEM_SZ_H: data = {{16{~uns & half_v[15]}}, half_v};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, bus FSM and result register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MEM_IDLE | no bus activity; non-memory and misaligned ops retire here
// MEM_REQ  | dmem.req high, bus fields decoded from the EX/MEM register
// MEM_RESP | load granted, waiting for rvalid
//
// The FSM enters MEM_REQ on the same edge that captures an aligned memory
// op, so the request is visible in the first cycle after capture. The
// register's valid bit is cleared when the access completes so the stage
// does not re-issue the op once back in MEM_IDLE.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_alu_res,
    input  logic [31:0] EX_mem_din,
    input  logic        EX_vld,
    input  logic        EX_mem_rd,
    input  logic        EX_mem_wr,
    input  logic [1:0]  EX_mem_size,
    input  logic        EX_mem_uns,
    output logic        MEM_stall,
    output logic [31:0] MEM_data,
    output logic        MEM_vld,
    output logic        MEM_misalign,
    mem_stage_if.master dmem
);

    mem_state_e  state_q, state_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] din_q, din_d;
    logic        vld_q, vld_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mem_vld_q, mem_vld_d;
    logic        misalign_q, misalign_d;

    logic        reg_mem_op;
    logic        reg_aligned;
    logic        capture;
    logic        ex_mem_op;
    logic        ex_mis;
    logic        in_req;
    logic [31:0] load_val;

    mem_load_align u_load_align (
        .rdata (dmem.rdata),
        .addr  (alu_res_q[1:0]),
        .size  (size_q),
        .uns   (uns_q),
        .data  (load_val)
    );

    // Stall and bus decode; bus fields are zero whenever no request is out.
    always_comb begin
        reg_mem_op  = vld_q & (rd_q | wr_q);
        reg_aligned = ~mem_misaligned(size_q, alu_res_q[1:0]);
        MEM_stall   = (state_q != MEM_IDLE) | (reg_mem_op & reg_aligned);
        capture     = ~MEM_stall;
        ex_mem_op   = EX_vld & (EX_mem_rd | EX_mem_wr);
        ex_mis      = mem_misaligned(EX_mem_size, EX_alu_res[1:0]);

        in_req      = (state_q == MEM_REQ);
        dmem.req    = in_req;
        dmem.we     = in_req & wr_q;
        dmem.addr   = in_req ? {alu_res_q[ADDR_W-1:2], 2'b00} : '0;
        dmem.be     = in_req ? mem_be(size_q, alu_res_q[1:0]) : 4'h0;
        dmem.wdata  = in_req ? mem_wdata(size_q, din_q) : 32'h0;
    end

    // Next-state: register capture, FSM transitions, one-cycle result pulse.
    always_comb begin
        state_d    = state_q;
        alu_res_d  = alu_res_q;
        din_d      = din_q;
        vld_d      = vld_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        mem_data_d = mem_data_q;
        mem_vld_d  = 1'b0;
        misalign_d = 1'b0;

        if (capture) begin
            alu_res_d = EX_alu_res;
            din_d     = EX_mem_din;
            vld_d     = EX_vld;
            rd_d      = EX_mem_rd;
            wr_d      = EX_mem_wr;
            size_d    = EX_mem_size;
            uns_d     = EX_mem_uns;
        end

        case (state_q)
            MEM_IDLE: begin
                if (capture && EX_vld) begin
                    if (ex_mem_op && !ex_mis) begin
                        state_d = MEM_REQ;
                    end else begin
                        mem_vld_d  = 1'b1;
                        mem_data_d = EX_alu_res;
                        misalign_d = ex_mem_op;
                    end
                end
            end
            MEM_REQ: begin
                if (dmem.gnt) begin
                    if (wr_q) begin
                        state_d    = MEM_IDLE;
                        vld_d      = 1'b0;
                        mem_vld_d  = 1'b1;
                        mem_data_d = 32'h0;
                    end else begin
                        state_d = MEM_RESP;
                    end
                end
            end
            MEM_RESP: begin
                if (dmem.rvalid) begin
                    state_d    = MEM_IDLE;
                    vld_d      = 1'b0;
                    mem_vld_d  = 1'b1;
                    mem_data_d = load_val;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MEM_IDLE;
            alu_res_q  <= 32'h0;
            din_q      <= 32'h0;
            vld_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= MEM_SZ_B;
            uns_q      <= 1'b0;
            mem_data_q <= 32'h0;
            mem_vld_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_res_q  <= alu_res_d;
            din_q      <= din_d;
            vld_q      <= vld_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            mem_data_q <= mem_data_d;
            mem_vld_q  <= mem_vld_d;
            misalign_q <= misalign_d;
        end
    end

    assign MEM_data     = mem_data_q;
    assign MEM_vld      = mem_vld_q;
    assign MEM_misalign = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment,
// back-to-back ordering and reset in the middle of a request.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] EX_alu_res;
    logic [31:0] EX_mem_din;
    logic        EX_vld;
    logic        EX_mem_rd;
    logic        EX_mem_wr;
    logic [1:0]  EX_mem_size;
    logic        EX_mem_uns;
    logic        MEM_stall;
    logic [31:0] MEM_data;
    logic        MEM_vld;
    logic        MEM_misalign;

    int checks = 0;
    int errors = 0;

    mem_stage_if #(.ADDR_W(32)) dmem_bus ();

    mem_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .EX_alu_res   (EX_alu_res),
        .EX_mem_din   (EX_mem_din),
        .EX_vld       (EX_vld),
        .EX_mem_rd    (EX_mem_rd),
        .EX_mem_wr    (EX_mem_wr),
        .EX_mem_size  (EX_mem_size),
        .EX_mem_uns   (EX_mem_uns),
        .MEM_stall    (MEM_stall),
        .MEM_data     (MEM_data),
        .MEM_vld      (MEM_vld),
        .MEM_misalign (MEM_misalign),
        .dmem         (dmem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ex(input logic v, input logic r, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] alu, input logic [31:0] din);
        EX_vld = v; EX_mem_rd = r; EX_mem_wr = w; EX_mem_size = sz;
        EX_mem_uns = u; EX_alu_res = alu; EX_mem_din = din;
    endtask

    task automatic set_idle();
        set_ex(1'b0, 1'b0, 1'b0, MEM_SZ_B, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (MEM_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", MEM_vld); end
        checks++; if (MEM_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", MEM_data); end
        checks++; if (MEM_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", MEM_misalign); end
        checks++; if (MEM_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", MEM_stall); end
        checks++; if ({dmem_bus.req, dmem_bus.we} !== 2'b00) begin errors++; $display("FAIL reset_req_we: got %b expected 00", {dmem_bus.req, dmem_bus.we}); end
        checks++; if (dmem_bus.addr !== 32'h0 || dmem_bus.be !== 4'h0 || dmem_bus.wdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus: got addr %h be %b wdata %h expected zeros", dmem_bus.addr, dmem_bus.be, dmem_bus.wdata); end
        rst = 1'b1;
    endtask

    task automatic test_alu();
        @(negedge clk);
        set_ex(1'b1, 1'b0, 1'b0, MEM_SZ_W, 1'b0, 32'h0000_1234, 32'h5555_5555);
        checks++; if (MEM_stall !== 1'b0) begin errors++; $display("FAIL alu_stall_pre: got %b expected 0", MEM_stall); end
        @(negedge clk);
        set_idle();
        checks++; if (MEM_vld !== 1'b1) begin errors++; $display("FAIL alu_vld: got %b expected 1", MEM_vld); end
        checks++; if (MEM_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data: got %h expected 00001234", MEM_data); end
        checks++; if (MEM_misalign !== 1'b0) begin errors++; $display("FAIL alu_misalign: got %b expected 0", MEM_misalign); end
        checks++; if ({dmem_bus.req, MEM_stall} !== 2'b00) begin errors++; $display("FAIL alu_req_stall: got %b expected 00", {dmem_bus.req, MEM_stall}); end
        @(negedge clk);
        checks++; if (MEM_vld !== 1'b0) begin errors++; $display("FAIL alu_pulse: got %b expected 0", MEM_vld); end
    endtask

    // LB/LBU at 0x103 with gnt two cycles late; optionally an rvalid in the
    // grant cycle, which must be ignored.
    task automatic test_load(input logic uns, input logic [31:0] exp, input bit early_rv);
        @(negedge clk);
        set_ex(1'b1, 1'b1, 1'b0, MEM_SZ_B, uns, 32'h0000_0103, 32'h0);
        checks++; if (MEM_stall !== 1'b0) begin errors++; $display("FAIL load_stall_pre: got %b expected 0", MEM_stall); end
        @(negedge clk);
        set_idle();
        for (int g = 0; g < 3; g++) begin
            checks++; if ({dmem_bus.req, dmem_bus.we, MEM_stall, MEM_vld} !== 4'b1010) begin
                errors++; $display("FAIL load_req_wait%0d: got req/we/stall/vld %b expected 1010", g, {dmem_bus.req, dmem_bus.we, MEM_stall, MEM_vld}); end
            checks++; if (dmem_bus.addr !== 32'h0000_0100 || dmem_bus.be !== 4'b1000) begin
                errors++; $display("FAIL load_addr_be%0d: got %h/%b expected 00000100/1000", g, dmem_bus.addr, dmem_bus.be); end
            if (g == 2) begin
                dmem_bus.gnt = 1'b1;
                if (early_rv) begin dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'hFFFF_FFFF; end
            end
            @(negedge clk);
        end
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        checks++; if ({dmem_bus.req, MEM_stall, MEM_vld} !== 3'b010) begin
            errors++; $display("FAIL load_resp_wait: got req/stall/vld %b expected 010", {dmem_bus.req, MEM_stall, MEM_vld}); end
        dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h80AB_CDEF;
        @(negedge clk);
        dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        checks++; if (MEM_vld !== 1'b1) begin errors++; $display("FAIL load_vld: got %b expected 1", MEM_vld); end
        checks++; if (MEM_data !== exp) begin errors++; $display("FAIL load_data: got %h expected %h", MEM_data, exp); end
        checks++; if ({MEM_stall, MEM_misalign} !== 2'b00) begin errors++; $display("FAIL load_done_stall: got stall/mis %b expected 00", {MEM_stall, MEM_misalign}); end
        @(negedge clk);
        checks++; if (MEM_vld !== 1'b0) begin errors++; $display("FAIL load_pulse: got %b expected 0", MEM_vld); end
    endtask

    task automatic test_store();
        @(negedge clk);
        set_ex(1'b1, 1'b0, 1'b1, MEM_SZ_H, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF);
        @(negedge clk);
        set_idle();
        dmem_bus.gnt = 1'b1;
        checks++; if ({dmem_bus.req, dmem_bus.we, MEM_stall} !== 3'b111) begin
            errors++; $display("FAIL store_req: got req/we/stall %b expected 111", {dmem_bus.req, dmem_bus.we, MEM_stall}); end
        checks++; if (dmem_bus.addr !== 32'h0000_0200) begin errors++; $display("FAIL store_addr: got %h expected 00000200", dmem_bus.addr); end
        checks++; if (dmem_bus.be !== 4'b1100) begin errors++; $display("FAIL store_be: got %b expected 1100", dmem_bus.be); end
        checks++; if (dmem_bus.wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL store_wdata: got %h expected BEEFBEEF", dmem_bus.wdata); end
        @(negedge clk);
        dmem_bus.gnt = 1'b0;
        checks++; if (MEM_vld !== 1'b1 || MEM_data !== 32'h0) begin
            errors++; $display("FAIL store_done: got vld %b data %h expected 1 00000000", MEM_vld, MEM_data); end
        checks++; if ({dmem_bus.req, MEM_stall} !== 2'b00) begin errors++; $display("FAIL store_idle: got req/stall %b expected 00", {dmem_bus.req, MEM_stall}); end
        @(negedge clk);
        checks++; if (MEM_vld !== 1'b0) begin errors++; $display("FAIL store_pulse: got %b expected 0", MEM_vld); end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        set_ex(1'b1, 1'b1, 1'b0, MEM_SZ_W, 1'b0, 32'h0000_0301, 32'h0);
        checks++; if (MEM_stall !== 1'b0) begin errors++; $display("FAIL mis_lw_stall: got %b expected 0", MEM_stall); end
        @(negedge clk);
        set_ex(1'b1, 1'b0, 1'b1, MEM_SZ_H, 1'b0, 32'h0000_0403, 32'h1111_2222);
        checks++; if ({MEM_vld, MEM_misalign} !== 2'b11) begin errors++; $display("FAIL mis_lw_flags: got vld/mis %b expected 11", {MEM_vld, MEM_misalign}); end
        checks++; if (MEM_data !== 32'h0000_0301) begin errors++; $display("FAIL mis_lw_data: got %h expected 00000301", MEM_data); end
        checks++; if ({dmem_bus.req, MEM_stall} !== 2'b00) begin errors++; $display("FAIL mis_lw_req: got req/stall %b expected 00", {dmem_bus.req, MEM_stall}); end
        @(negedge clk);
        set_idle();
        checks++; if ({MEM_vld, MEM_misalign} !== 2'b11 || MEM_data !== 32'h0000_0403) begin
            errors++; $display("FAIL mis_sh: got vld/mis %b data %h expected 11 00000403", {MEM_vld, MEM_misalign}, MEM_data); end
        checks++; if ({dmem_bus.req, dmem_bus.we} !== 2'b00) begin errors++; $display("FAIL mis_sh_req: got req/we %b expected 00", {dmem_bus.req, dmem_bus.we}); end
        @(negedge clk);
        checks++; if ({MEM_vld, MEM_misalign} !== 2'b00) begin errors++; $display("FAIL mis_pulse: got vld/mis %b expected 00", {MEM_vld, MEM_misalign}); end
    endtask

    // ADD, LW (gnt held low 3 cycles), ADD with a simple upstream that holds
    // on MEM_stall and a responder that answers one cycle after gnt.
    task automatic test_back_to_back();
        logic [31:0] prog_alu [3];
        logic        prog_rd  [3];
        logic [31:0] exp_data [3];
        logic [31:0] got_data [8];
        int          idx = 0;
        int          npulse = 0;
        int          held = 0;
        int          wait_cnt = 0;
        bit          resp_pending = 1'b0;
        prog_alu[0] = 32'h0000_0011; prog_rd[0] = 1'b0;
        prog_alu[1] = 32'h0000_0400; prog_rd[1] = 1'b1;
        prog_alu[2] = 32'h0000_0022; prog_rd[2] = 1'b0;
        exp_data[0] = 32'h0000_0011; exp_data[1] = 32'h1234_5678; exp_data[2] = 32'h0000_0022;
        for (int i = 0; i < 8; i++) got_data[i] = 32'h0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (MEM_vld === 1'b1) begin
                if (npulse < 8) got_data[npulse] = MEM_data;
                npulse++;
            end
            dmem_bus.rvalid = resp_pending;
            dmem_bus.rdata  = resp_pending ? 32'h1234_5678 : 32'hDEAD_DEAD;
            resp_pending = 1'b0;
            dmem_bus.gnt = 1'b0;
            if (dmem_bus.req === 1'b1) begin
                if (wait_cnt < 3) wait_cnt++;
                else begin dmem_bus.gnt = 1'b1; resp_pending = 1'b1; end
            end
            if (idx < 3) set_ex(1'b1, prog_rd[idx], 1'b0, MEM_SZ_W, 1'b0, prog_alu[idx], 32'h0);
            else set_idle();
            if (idx < 3 && MEM_stall === 1'b0) idx++;
            else if (idx == 2) held++;
        end
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        checks++; if (npulse !== 3) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 3", npulse); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got_data[i] !== exp_data[i]) begin errors++; $display("FAIL b2b_order%0d: got %h expected %h", i, got_data[i], exp_data[i]); end
        end
        checks++; if (held < 1) begin errors++; $display("FAIL b2b_held: got %0d held cycles expected at least 1", held); end
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_issued: got %0d issued expected 3", idx); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_ex(1'b1, 1'b1, 1'b0, MEM_SZ_W, 1'b0, 32'h0000_0500, 32'h0);
        @(negedge clk);
        set_idle();
        checks++; if (dmem_bus.req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before: got %b expected 1", dmem_bus.req); end
        #1 rst = 1'b0;
        #1;
        checks++; if (dmem_bus.req !== 1'b0) begin errors++; $display("FAIL rstmid_req_async: got %b expected 0", dmem_bus.req); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({dmem_bus.req, MEM_stall} !== 2'b00) begin errors++; $display("FAIL rstmid_idle: got req/stall %b expected 00", {dmem_bus.req, MEM_stall}); end
        dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        checks++; if (MEM_vld !== 1'b0) begin errors++; $display("FAIL rstmid_stray_rvalid: got vld %b expected 0", MEM_vld); end
        @(negedge clk);
        checks++; if ({MEM_vld, MEM_stall} !== 2'b00) begin errors++; $display("FAIL rstmid_quiet: got vld/stall %b expected 00", {MEM_vld, MEM_stall}); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load(1'b0, 32'hFFFF_FF80, 1'b0);
        test_load(1'b1, 32'h0000_0080, 1'b1);
        test_store();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the in-order pipeline, directly downstream of the execute stage. Captures the execute result, store data and valid bit into its EX/MEM register, performs byte/half/word loads and stores over a req/gnt/rvalid data-memory bus, and produces the registered `MEM_data`. `MEM_data` feeds writeback and returns to execute as forward source F1. The stage stalls upstream while a bus transaction is in flight.

## Interface
Parameters
- `ADDR_W`, 32: data-memory address width; `dmem_addr` is the full byte address.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `EX_alu_res`  in  32  ALU result; effective address for loads and stores.
- `EX_mem_din`  in  32  store data (rs2).
- `EX_vld`  in  1  execute output valid.
- `EX_mem_rd`  in  1  instruction is a load.
- `EX_mem_wr`  in  1  instruction is a store.
- `EX_mem_size`  in  2  access size: `MEM_SZ_B`=0, `MEM_SZ_H`=1, `MEM_SZ_W`=2.
- `EX_mem_uns`  in  1  load zero-extends (LBU/LHU).
- `MEM_stall`  out  1  upstream must hold; EX values are not captured this cycle.
- `MEM_data`  out  32  registered result: ALU result or aligned load data.
- `MEM_vld`  out  1  `MEM_data` valid this cycle; one pulse per instruction.
- `MEM_misalign`  out  1  registered; pulses with `MEM_vld` when the access was misaligned.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  bus write enable.
- `dmem_addr`  out  ADDR_W  word-aligned address (`[1:0]`=0).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  store data replicated onto the lanes.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  load data.

## Operation
- EX/MEM register (`alu_res`, `din`, `vld`, `rd`, `wr`, `size`, `uns`): loads when `MEM_stall`=0.
- FSM states:
  - IDLE: leaves for REQ when the register holds a valid, aligned memory op.
  - REQ: `dmem_req`=1 and bus outputs are driven from the register. If `dmem_gnt`=1: a store goes to IDLE; a load goes to RESP.
  - RESP: waits for `dmem_rvalid`, then goes to IDLE.
- `MEM_stall` = (state != IDLE) OR (state==IDLE AND the register holds a valid, aligned memory op). It is combinational.
- Non-memory op (`vld`=1, `rd`=`wr`=0): passes through with no stall; `MEM_data`=`alu_res`.
- Misalignment: half-word with `addr[0]`=1, or word with `addr[1:0]`!=0. No bus request is issued, no stall occurs, `MEM_vld`=1 with `MEM_misalign`=1, and `MEM_data`=`alu_res`.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<addr[1:0]`
  - word: `4'hF`
- Write data:
  - byte: `{4{din[7:0]}}`
  - half: `{2{din[15:0]}}`
  - word: `din`
- Load data: select the byte or half selected by `addr[1:0]` from `dmem_rdata`, then sign-extend, or zero-extend when `uns`=1.
- Store completion: `MEM_vld`=1 and `MEM_data`=0.
- `rd` and `wr` both set: decode error. Treat it as a store.
- `vld`=0 in the register: no action, no `MEM_vld`.

## Timing
- Reset values: state IDLE, register `vld`=0, `MEM_vld`=0, `MEM_data`=0, `MEM_misalign`=0, `dmem_req`=0, `dmem_we`=0, `dmem_be`=0, `dmem_addr`=0, `dmem_wdata`=0.
- Non-memory or misaligned op: captured at edge N; `MEM_vld` asserts in cycle N+1. Back-to-back throughput is 1 per cycle.
- Load: captured at edge N; `dmem_req` is high from cycle N+1. `dmem_gnt` is sampled at the edge ending cycle N+1+g, and `dmem_rvalid` at the edge ending cycle N+1+g+r. `MEM_vld` and load data assert in the following cycle. Minimum latency is 3 cycles (g=0, r=1).
- Store: `MEM_vld` asserts in the cycle after the `dmem_gnt` edge. Minimum latency is 2 cycles.
- Bus outputs stay stable while `dmem_req`=1 and `dmem_gnt`=0.
- `dmem_rvalid` arriving in the same cycle as `dmem_gnt` is ignored. The bus guarantees that rvalid follows gnt by at least 1 cycle.
- `rst` low mid-transaction: `dmem_req` drops immediately. The outstanding response is discarded after reset; rvalid is ignored in IDLE.
- `MEM_vld` is a 1-cycle pulse and is never held across stalls.

## Structure
- `sys_defs.vh` gets:
  - the size encodings `MEM_SZ_B`, `MEM_SZ_H`, `MEM_SZ_W`;
  - the FSM state encodings `MEM_IDLE`, `MEM_REQ`, `MEM_RESP`.
- One combinational sub-module, `mem_load_align`, takes `rdata`, `addr[1:0]`, `size` and `uns` and returns the 32-bit extended load value.
- The EX/MEM register, FSM and store lane logic live in `mem_stage`.

## Test plan
- ADD result `32'h0000_1234`, `rd`=`wr`=0 -> no `dmem_req`, `MEM_vld` next cycle, `MEM_data`=`32'h0000_1234`, `MEM_stall` never 1.
- LB addr `32'h103`, `dmem_rdata`=`32'h80AB_CDEF`, gnt delayed 2 cycles, rvalid 1 cycle later -> `dmem_addr`=`32'h100`, `dmem_be`=`4'b1000`, `MEM_data`=`32'hFFFF_FF80`. LBU on the same access -> `32'h0000_0080`. `MEM_stall` high until the edge that samples rvalid.
- SH addr `32'h202`, `din`=`32'hDEAD_BEEF`, gnt immediate -> `dmem_we`=1, `dmem_be`=`4'b1100`, `dmem_wdata`=`32'hBEEF_BEEF`, `MEM_vld` 2 cycles after capture with `MEM_data`=0.
- LW addr `32'h301` -> no request, `MEM_misalign`=1 and `MEM_vld`=1 next cycle, `MEM_data`=`32'h301`.
- ADD, LW (gnt held low 3 cycles), ADD back-to-back -> the second ADD is held by `MEM_stall`; `MEM_vld` pulses occur in program order, exactly three of them.
- `rst` asserted while in REQ -> `dmem_req` falls without a clock edge; after release, state is IDLE and a stray `dmem_rvalid` produces no `MEM_vld`.
